// File: rtl/lsu_byte_seq.sv
// Load/store sequencer: splits LB/LH/LW/LBU/LHU/SB/SH/SW into byte-wide memory cycles.
// Latency: accept at edge k, bytes in cycles k+1..k+N, resp_valid in cycle k+N+1.
// Backpressure: req_ready is high only in IDLE; the core holds its request until accepted.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            core request handshake
//   req_write/fun3/addr/wdata      request attributes, latched on accept
//   resp_valid/rdata/err           one-cycle completion pulse with extended load data
//   mem_read/write/fun3/addr/wdata memory port (byte-addressed)
//   mem_rdata                      memory read data, combinational from mem_addr
//
// Optional build macro LSU_ALIGNED_FAST_EN: aligned accesses use one native-width
// memory cycle; misaligned ones stay byte-serial.
module lsu_byte_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_fun3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_fun3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state_q, state_d;
  logic              wr_q;
  logic [2:0]        fun3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [1:0]        idx_q;
  logic              err_q;
  logic              fast_q;

  logic              accept;
  logic              req_legal;
  logic              req_fast;
  logic              byte_last;
  logic [ADDR_W-1:0] cur_addr;

  function automatic logic fun3_legal(input logic wr, input logic [2:0] f);
    if (wr) return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
    return (f != 3'b011) && (f != 3'b110) && (f != 3'b111);
  endfunction

  // Index of the final byte: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] last_idx(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Gating with rst_n keeps req_ready low for as long as reset is asserted.
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign req_legal = fun3_legal(req_write, req_fun3);

`ifdef LSU_ALIGNED_FAST_EN
  assign req_fast = (req_fun3[1:0] == 2'b00) ||
                    ((req_fun3[1:0] == 2'b01) && !req_addr[0]) ||
                    ((req_fun3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00));
`else
  assign req_fast = 1'b0;
`endif

  // Address arithmetic wraps naturally at 2^ADDR_W.
  assign cur_addr  = addr_q + ADDR_W'(idx_q);
  assign byte_last = fast_q || (idx_q == last_idx(fun3_q));

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_fun3   = 3'b000;
    mem_wdata  = 32'h0;
    mem_addr   = last_addr_q;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = req_legal ? XFER : RESP;
      end
      XFER: begin
        mem_addr = cur_addr;
        if (wr_q) begin
          mem_write = 1'b1;
          mem_fun3  = fast_q ? fun3_q : 3'b000;
          mem_wdata = fast_q ? wdata_q : {24'h0, wdata_q[8*idx_q +: 8]};
        end else begin
          mem_read = 1'b1;
          mem_fun3 = fast_q ? fun3_q : 3'b100;
        end
        if (byte_last) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !wr_q) begin
          if (fast_q) begin
            // Memory already extended the value for the native fun3.
            resp_rdata = asm_q;
          end else begin
            case (fun3_q)
              3'b000:  resp_rdata = {{24{asm_q[7]}}, asm_q[7:0]};
              3'b001:  resp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
              3'b010:  resp_rdata = asm_q;
              3'b100:  resp_rdata = {24'h0, asm_q[7:0]};
              3'b101:  resp_rdata = {16'h0, asm_q[15:0]};
              default: resp_rdata = 32'h0;
            endcase
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      fun3_q      <= 3'b000;
      addr_q      <= '0;
      last_addr_q <= '0;
      wdata_q     <= 32'h0;
      asm_q       <= 32'h0;
      idx_q       <= 2'd0;
      err_q       <= 1'b0;
      fast_q      <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write;
        fun3_q  <= req_fun3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        idx_q   <= 2'd0;
        asm_q   <= 32'h0;
        err_q   <= !req_legal;
        fast_q  <= req_fast && req_legal;
      end else if (state_q == XFER) begin
        last_addr_q <= cur_addr;
        idx_q       <= idx_q + 2'd1;
        if (!wr_q) begin
          if (fast_q) asm_q <= mem_rdata;
          else        asm_q[8*idx_q +: 8] <= mem_rdata[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Bench for lsu_byte_seq: directed steps from the test plan plus random traffic,
// checked cycle by cycle against a byte-array reference memory.
// Honours LSU_ALIGNED_FAST_EN when the build defines it.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_fun3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_fun3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_fun3(mem_fun3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-addressable data memory the DUT talks to.
  logic [7:0] dev_mem [256] = '{default: 8'h00};
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = dev_mem[mem_addr];
    b1 = dev_mem[8'(mem_addr + 8'd1)];
    b2 = dev_mem[8'(mem_addr + 8'd2)];
    b3 = dev_mem[8'(mem_addr + 8'd3)];
    case (mem_fun3)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b100:  mem_rdata = {24'h0, b0};
      3'b101:  mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (i < (mem_fun3[1:0] == 2'b00 ? 1 : mem_fun3[1:0] == 2'b01 ? 2 : 4))
          dev_mem[8'(mem_addr + 8'(i))] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Reference memory: what the data memory should contain after each completed store.
  logic [7:0] ref_mem [256];
  logic [7:0] last_maddr = 8'h00;

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [7:0] a);
    logic [31:0] v;
    v = 32'(ref_mem[a]) + (32'(ref_mem[8'(a + 8'd1)]) << 8) +
        (32'(ref_mem[8'(a + 8'd2)]) << 16) + (32'(ref_mem[8'(a + 8'd3)]) << 24);
    case (f)
      3'b000:  return (v & 32'h80) != 0 ? (v & 32'hFF) | 32'hFFFFFF00 : v & 32'hFF;
      3'b001:  return (v & 32'h8000) != 0 ? (v & 32'hFFFF) | 32'hFFFF0000 : v & 32'hFFFF;
      3'b010:  return v;
      3'b100:  return v & 32'hFF;
      3'b101:  return v & 32'hFFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check every cycle until one idle cycle after the response.
  // spur raises req_valid for a cycle while busy; it must be ignored.
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input logic spur, output logic [31:0] got);
    logic        legal;
    logic        fast;
    int          n, ncyc, lat;
    logic [31:0] exp_rd;
    logic [7:0]  ea;
    legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    fast = 1'b0;
`ifdef LSU_ALIGNED_FAST_EN
    fast = legal && (n == 1 || (n == 2 && !a[0]) || (n == 4 && a[1:0] == 2'b00));
`endif
    ncyc   = !legal ? 0 : (fast ? 1 : n);
    lat    = ncyc + 1;
    exp_rd = (legal && !wr) ? ref_load(f3, a) : 32'h0;
    got    = 32'h0;

    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_fun3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble inputs: the DUT must be working from its latched copy.
    req_valid = spur;
    req_write = 1'($urandom); req_fun3 = 3'($urandom);
    req_addr  = 8'($urandom); req_wdata = $urandom;

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 2) req_valid = 1'b0;
      if (c <= ncyc) begin
        ea = fast ? a : 8'(a + 8'(c - 1));
        chk("mem_read", 32'(mem_read), 32'(!wr));
        chk("mem_write", 32'(mem_write), 32'(wr));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_fun3", 32'(mem_fun3), fast ? 32'(f3) : (wr ? 32'd0 : 32'd4));
        chk("mem_wdata", mem_wdata,
            !wr ? 32'h0 : fast ? wd : (wd >> (8 * (c - 1))) & 32'hFF);
        chk("resp_early", 32'(resp_valid), 32'd0);
        chk("ready_busy", 32'(req_ready), 32'd0);
        last_maddr = ea;
      end else if (c == lat) begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(!legal));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("mem_idle_resp", 32'({mem_read, mem_write}), 32'd0);
        chk("ready_resp", 32'(req_ready), 32'd0);
        got = resp_rdata;
      end else begin
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("mem_idle", 32'({mem_read, mem_write, mem_fun3}), 32'd0);
        chk("mem_wdata_idle", mem_wdata, 32'h0);
        chk("mem_addr_hold", 32'(mem_addr), 32'(last_maddr));
      end
    end
    if (legal && wr)
      for (int i = 0; i < n; i++) ref_mem[8'(a + 8'(i))] = wd[8*i +: 8];
  endtask

`ifdef LSU_ALIGNED_FAST_EN
  localparam logic [7:0] RST_A = 8'h21;
`else
  localparam logic [7:0] RST_A = 8'h20;
`endif

  logic [31:0] got;
  logic        r_wr;
  logic [2:0]  r_f3;
  logic [7:0]  r_a;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_fun3 = 3'b000; req_addr = 8'h00; req_wdata = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp", 32'({resp_valid, resp_err}), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem", 32'({mem_read, mem_write, mem_fun3}), 32'd0);
    chk("rst_maddr", 32'(mem_addr), 32'd0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed test-plan steps.
    run_op(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0, got);
    chk("sw_rdata", got, 32'h0);
    run_op(1'b0, 3'b010, 8'h10, 32'h0, 1'b0, got);
    chk("lw_const", got, 32'hDEADBEEF);
    run_op(1'b0, 3'b000, 8'h10, 32'h0, 1'b0, got);
    chk("lb_const", got, 32'hFFFFFFEF);
    run_op(1'b0, 3'b100, 8'h10, 32'h0, 1'b0, got);
    chk("lbu_const", got, 32'h000000EF);
    run_op(1'b0, 3'b101, 8'h12, 32'h0, 1'b0, got);
    chk("lhu_const", got, 32'h0000DEAD);
    run_op(1'b1, 3'b001, 8'hFF, 32'h00001234, 1'b0, got);
    chk("wrap_mem_ff", 32'(dev_mem[8'hFF]), 32'h34);
    chk("wrap_mem_00", 32'(dev_mem[8'h00]), 32'h12);
    run_op(1'b0, 3'b001, 8'hFF, 32'h0, 1'b0, got);
    chk("lh_wrap_const", got, 32'h00001234);
    run_op(1'b0, 3'b011, 8'h10, 32'h0, 1'b0, got);
    run_op(1'b1, 3'b100, 8'h10, 32'hFFFFFFFF, 1'b0, got);
    run_op(1'b0, 3'b010, 8'h11, 32'h0, 1'b1, got);
    run_op(1'b1, 3'b000, 8'h13, 32'hA5A5A5A5, 1'b1, got);

    // Reset in the middle of a store: only the first two bytes may land.
    run_op(1'b1, 3'b010, RST_A, 32'h0, 1'b0, got);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_fun3 = 3'b010;
    req_addr = RST_A; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_write", 32'(mem_write), 32'd0);
    chk("abort_resp", 32'(resp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", 32'(req_ready), 32'd1);
    ref_mem[RST_A] = 8'h44;
    ref_mem[8'(RST_A + 8'd1)] = 8'h33;
    last_maddr = 8'h00;
    for (int i = 0; i < 4; i++)
      chk("abort_bytes", 32'(dev_mem[8'(RST_A + 8'(i))]), 32'(ref_mem[8'(RST_A + 8'(i))]));

    // Random traffic clustered near the wrap point so loads see earlier stores.
    for (int t = 0; t < 60; t++) begin
      r_wr = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        r_f3 = r_wr ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 4) < 3) ?
               3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
      else
        r_f3 = 3'($urandom);
      r_a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 7));
      run_op(r_wr, r_f3, r_a, $urandom, 1'($urandom), got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
